// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: dbus has priority, an aging counter keeps ibus from starving.
// The winner's request is latched for the downstream bus, and the completion is routed back to the owner.
module mem_bus_arbiter #(
  parameter int unsigned AGE_LIMIT = 4,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [2:0]            i_size,
  output logic                  i_data_ok,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_valid,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [2:0]            d_size,
  input  logic [DATA_W/8-1:0]   d_strobe,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_data_ok,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  c_valid,
  output logic [ADDR_W-1:0]     c_addr,
  output logic [2:0]            c_size,
  output logic [DATA_W/8-1:0]   c_strobe,
  output logic [DATA_W-1:0]     c_wdata,
  input  logic                  c_done,
  input  logic [DATA_W-1:0]     c_rdata,
  output logic                  busy,
  output logic                  owner
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned AGE_W  = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [AGE_W-1:0]    age_q, age_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [STRB_W-1:0]   strobe_q, strobe_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                d_win, i_win, done_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      age_q    <= '0;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      age_q    <= age_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
    end
  end

  // Arbitration, request latching and completion routing.
  always_comb begin
    state_d   = state_q;
    age_d     = age_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    size_d    = size_q;
    strobe_d  = strobe_q;
    wdata_d   = wdata_q;
    d_win     = 1'b0;
    i_win     = 1'b0;
    done_c    = 1'b0;
    i_data_ok = 1'b0;
    d_data_ok = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;

    case (state_q)
      IDLE: begin
        d_win = d_valid && !(i_valid && (age_q == AGE_MAX));
        i_win = !d_win && i_valid;
        if (d_win) begin
          state_d  = BUSY;
          owner_d  = 1'b1;
          addr_d   = d_addr;
          size_d   = d_size;
          strobe_d = d_strobe;
          wdata_d  = d_wdata;
          if (i_valid && (age_q != AGE_MAX)) age_d = age_q + AGE_W'(1);
        end else if (i_win) begin
          state_d  = BUSY;
          owner_d  = 1'b0;
          addr_d   = i_addr;
          size_d   = i_size;
          strobe_d = '0;
          wdata_d  = '0;
          age_d    = '0;
        end
      end
      BUSY: begin
        done_c = c_done;
        if (c_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A requester that already dropped valid gets no pulse; the store still completes.
    if (done_c && owner_q) begin
      d_data_ok = d_valid;
      d_rdata   = c_rdata;
    end else if (done_c && !owner_q) begin
      i_data_ok = i_valid;
      i_rdata   = c_rdata;
    end
  end

  assign busy     = (state_q == BUSY);
  assign c_valid  = (state_q == BUSY);
  assign owner    = owner_q;
  assign c_addr   = addr_q;
  assign c_size   = size_q;
  assign c_strobe = strobe_q;
  assign c_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: hand-computed expectations for grants, latching, aging and reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, d_valid, c_done;
  logic [63:0] i_addr, d_addr, d_wdata, c_rdata;
  logic [2:0]  i_size, d_size;
  logic [7:0]  d_strobe;
  logic        i_data_ok, d_data_ok, c_valid, busy, owner;
  logic [63:0] i_rdata, d_rdata, c_addr, c_wdata;
  logic [2:0]  c_size;
  logic [7:0]  c_strobe;

  int nchk = 0;
  int nerr = 0;

  mem_bus_arbiter #(.AGE_LIMIT(4), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_size(i_size),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size),
    .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .c_valid(c_valid), .c_addr(c_addr), .c_size(c_size),
    .c_strobe(c_strobe), .c_wdata(c_wdata),
    .c_done(c_done), .c_rdata(c_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic       exp_own [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] exp_age [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

  initial begin
    reset = 1'b0; i_valid = 0; d_valid = 0; c_done = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; c_rdata = '0;
    i_size = '0; d_size = '0; d_strobe = '0;
    step(); step();
    reset = 1'b1;
    chk("rst_cvalid", 64'(c_valid), 64'd0);
    chk("rst_busy",   64'(busy),    64'd0);
    chk("rst_owner",  64'(owner),   64'd0);
    chk("rst_age",    64'(dut.age_q), 64'd0);
    chk("rst_caddr",  c_addr,       64'd0);

    // dbus read
    d_valid = 1; d_addr = 64'h8000_0008; d_size = 3'd3; d_strobe = 8'h00;
    step();
    chk("rd_cvalid", 64'(c_valid), 64'd1);
    chk("rd_caddr",  c_addr,       64'h8000_0008);
    chk("rd_csize",  64'(c_size),  64'd3);
    chk("rd_owner",  64'(owner),   64'd1);
    step(); step();
    chk("rd_nodone", 64'(d_data_ok), 64'd0);
    step();
    c_done = 1; c_rdata = 64'hDEAD_BEEF;
    #1;
    chk("rd_dok",   64'(d_data_ok), 64'd1);
    chk("rd_rdata", d_rdata,        64'hDEAD_BEEF);
    chk("rd_iok",   64'(i_data_ok), 64'd0);
    chk("rd_irdata", i_rdata,       64'd0);
    step();
    c_done = 0; d_valid = 0;
    chk("rd_idle", 64'(c_valid), 64'd0);
    step();
    chk("rd_stay_idle", 64'(busy), 64'd0);

    // simultaneous requests
    i_valid = 1; i_addr = 64'h1000; i_size = 3'd2;
    d_valid = 1; d_addr = 64'h2000; d_size = 3'd3; d_strobe = 8'hFF; d_wdata = 64'hAAAA;
    step();
    chk("sim_owner_d", 64'(owner), 64'd1);
    chk("sim_addr_d",  c_addr,     64'h2000);
    chk("sim_age1",    64'(dut.age_q), 64'd1);
    c_done = 1; c_rdata = 64'h55;
    #1;
    chk("sim_dok", 64'(d_data_ok), 64'd1);
    chk("sim_iok", 64'(i_data_ok), 64'd0);
    step();
    c_done = 0; d_valid = 0;
    chk("sim_bubble", 64'(c_valid), 64'd0);
    step();
    chk("sim_cvalid_i", 64'(c_valid),  64'd1);
    chk("sim_owner_i",  64'(owner),    64'd0);
    chk("sim_addr_i",   c_addr,        64'h1000);
    chk("sim_strobe_i", 64'(c_strobe), 64'd0);
    chk("sim_wdata_i",  c_wdata,       64'd0);
    chk("sim_age0",     64'(dut.age_q), 64'd0);
    c_done = 1; c_rdata = 64'h1234;
    #1;
    chk("sim_iok2",   64'(i_data_ok), 64'd1);
    chk("sim_irdata", i_rdata,        64'h1234);
    chk("sim_drdata", d_rdata,        64'd0);
    step();
    c_done = 0; i_valid = 0;

    // starvation: both held high continuously
    i_valid = 1; d_valid = 1; d_strobe = 8'h00;
    for (int g = 0; g < 10; g++) begin
      step();
      chk($sformatf("stv_owner%0d", g), 64'(owner), 64'(exp_own[g]));
      chk($sformatf("stv_age%0d", g),   64'(dut.age_q), 64'(exp_age[g]));
      c_done = 1;
      #1;
      chk($sformatf("stv_ok%0d", g),
          64'(exp_own[g] ? d_data_ok : i_data_ok), 64'd1);
      step();
      c_done = 0;
    end
    i_valid = 0; d_valid = 0;
    step();

    // store latching
    d_valid = 1; d_addr = 64'h3000; d_strobe = 8'h0F; d_wdata = 64'h1122_3344;
    step();
    d_wdata = 64'hFFFF_FFFF; d_strobe = 8'hFF; d_addr = 64'h0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("st_strobe%0d", k), 64'(c_strobe), 64'h0F);
      chk($sformatf("st_wdata%0d", k),  c_wdata,       64'h1122_3344);
    end
    c_done = 1;
    #1;
    chk("st_addr", c_addr, 64'h3000);
    chk("st_dok",  64'(d_data_ok), 64'd1);
    step();
    c_done = 0; d_valid = 0; d_strobe = 8'h00;
    step();

    // reset mid-BUSY
    i_valid = 1; i_addr = 64'h7000; d_valid = 1; d_addr = 64'h4000;
    step();
    chk("rb_busy",  64'(busy), 64'd1);
    chk("rb_age",   64'(dut.age_q), 64'd1);
    reset = 0; i_valid = 0; d_valid = 0;
    step();
    reset = 1;
    chk("rb_cvalid", 64'(c_valid), 64'd0);
    chk("rb_busy0",  64'(busy),    64'd0);
    chk("rb_age0",   64'(dut.age_q), 64'd0);
    step(); step();
    c_done = 1;
    #1;
    chk("rb_nodok", 64'(d_data_ok), 64'd0);
    chk("rb_noiok", 64'(i_data_ok), 64'd0);
    step();
    c_done = 0;
    chk("rb_idle", 64'(busy), 64'd0);

    // abandoned ibus request
    i_valid = 1; i_addr = 64'h5000;
    step();
    chk("ab_owner", 64'(owner), 64'd0);
    chk("ab_busy",  64'(busy),  64'd1);
    i_valid = 0; d_valid = 1; d_addr = 64'h6000;
    step();
    chk("ab_still", 64'(c_addr), 64'h5000);
    c_done = 1;
    #1;
    chk("ab_noiok", 64'(i_data_ok), 64'd0);
    chk("ab_nodok", 64'(d_data_ok), 64'd0);
    step();
    c_done = 0;
    chk("ab_idle", 64'(busy), 64'd0);
    step();
    chk("ab_dgrant", 64'(busy),  64'd1);
    chk("ab_downer", 64'(owner), 64'd1);
    chk("ab_daddr",  c_addr,     64'h6000);
    c_done = 1;
    #1;
    chk("ab_dok", 64'(d_data_ok), 64'd1);
    step();
    c_done = 0; d_valid = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one downstream memory bus between the instruction-fetch requester (ibus) and the memory-stage requester (dbus).
- Grants one transaction at a time. Latches the winner's request so the downstream bus sees stable fields, then routes the response back to the owner.
- dbus has fixed priority, with an aging counter so fetch cannot starve.
- Sits between the pipeline (fetch and memory stages) and the cache/memory port.

Parameters:
- AGE_LIMIT, 4: number of consecutive dbus wins over a pending ibus request before ibus is forced to win. Range 1..15.
- ADDR_W, 64: address width.
- DATA_W, 64: data width. Strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- i_valid  in  1  ibus request valid; held until i_data_ok
- i_addr  in  ADDR_W  ibus address
- i_size  in  3  ibus access size
- i_data_ok  out  1  one-cycle pulse: ibus transaction done
- i_rdata  out  DATA_W  ibus read data, valid with i_data_ok
- d_valid  in  1  dbus request valid; held until d_data_ok
- d_addr  in  ADDR_W  dbus address
- d_size  in  3  dbus access size
- d_strobe  in  DATA_W/8  byte write strobe; 0 means read
- d_wdata  in  DATA_W  store data
- d_data_ok  out  1  one-cycle pulse: dbus transaction done
- d_rdata  out  DATA_W  dbus read data, valid with d_data_ok
- c_valid  out  1  downstream request valid
- c_addr  out  ADDR_W  latched address
- c_size  out  3  latched size
- c_strobe  out  DATA_W/8  latched strobe; always 0 for ibus
- c_wdata  out  DATA_W  latched store data
- c_done  in  1  downstream completion pulse, arbitrary latency
- c_rdata  in  DATA_W  downstream read data, valid with c_done
- busy  out  1  high when state is BUSY
- owner  out  1  current or last grant: 0 = ibus, 1 = dbus

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; age=0; owner=0.
  - c_valid=0; latched addr/size/strobe/wdata=0.
  - i_data_ok=d_data_ok=0; busy=0.
  - Applies even mid-transaction. The in-flight transaction is abandoned and no data_ok is produced for it. A c_done that arrives later is ignored.
- States: IDLE, BUSY.
- IDLE, arbitration evaluated every cycle:
  - dbus wins if d_valid and not (i_valid and age==AGE_LIMIT).
  - Otherwise ibus wins if i_valid.
  - On a grant, at the next edge: latch the winner's fields (ibus strobe forced to 0, wdata to 0), set owner, go to BUSY.
  - With no request, stay in IDLE.
  - c_done in IDLE is ignored.
- Age counter:
  - In IDLE, when dbus wins while i_valid=1: age increments, saturating at AGE_LIMIT.
  - When ibus wins: age resets to 0.
  - Otherwise age holds.
- BUSY:
  - c_valid=1 with latched fields. Fields stay constant regardless of requester input changes.
  - On c_done, combinationally in the same cycle:
    - the owner's data_ok=1 if the owner's valid is still 1; otherwise the pulse is suppressed;
    - the owner's rdata=c_rdata.
  - At the next edge: state=IDLE, c_valid=0.
- Non-owner outputs: data_ok=0 and rdata=0 at all times.
- Latency:
  - Grant → c_valid: 1 cycle.
  - c_done → data_ok: 0 cycles.
  - There is a mandatory 1-cycle IDLE bubble between transactions, so a requester that drops valid after data_ok is never regranted a stale request.
- Requester drops valid mid-BUSY: the downstream transaction still completes (stores are not cancelled) and the arbiter returns to IDLE.
- Requesters must keep fields stable while valid=1 and not yet granted. Changes after the grant have no effect.
- busy=(state==BUSY).

Test Plan:
- dbus read:
  - Stimulus: d_valid=1, d_addr=0x80000008, d_size=3, d_strobe=0; c_done 3 cycles after c_valid with c_rdata=0xDEADBEEF.
  - Response: c_valid rises 1 cycle after the request with c_addr=0x80000008; d_data_ok=1 with d_rdata=0xDEADBEEF in the c_done cycle; i_data_ok stays 0.
- Simultaneous requests:
  - Stimulus: i_valid=d_valid=1 at cycle 0.
  - Response: dbus granted first; ibus c_valid appears exactly 1 IDLE cycle after dbus completes, with c_strobe=0.
- Starvation, AGE_LIMIT=4:
  - Stimulus: i_valid and d_valid held high continuously; each requester issues a new request immediately after its data_ok.
  - Response: grant order is D,D,D,D,I,D,D,D,D,I; age is 0 after each ibus grant.
- Store latching:
  - Stimulus: d_strobe=0x0F, d_wdata=0x11223344; d_wdata changed to 0xFFFFFFFF after the grant.
  - Response: c_strobe=0x0F and c_wdata=0x11223344 held until c_done.
- Reset mid-BUSY:
  - Stimulus: reset=0 for 1 cycle while BUSY, then c_done arrives 2 cycles later.
  - Response: c_valid=0, busy=0, age=0 after the reset edge; no data_ok pulse.
- Abandoned request:
  - Stimulus: ibus granted, then i_valid dropped before c_done.
  - Response: i_data_ok stays 0; state returns to IDLE after c_done; a pending dbus request is granted 1 cycle later.
